// File: rtl/fp_pkg.sv
// Shared definitions for the sequential floating-point divider.
// Holds width-generic helpers (bias, max exponent, canonical qNaN, field
// extraction), the controller state enum and the operand class struct.
// Helpers work on a MAX_W-wide carrier; callers zero-extend and truncate.
package fp_pkg;

  localparam int unsigned MAX_W = 64;

  typedef enum logic [1:0] {
    StIdle,
    StDivide,
    StNorm,
    StDone
  } fp_state_e;

  typedef struct packed {
    logic zero;
    logic inf;
    logic nan;
    logic normal;
  } fp_class_t;

  function automatic int unsigned bias_of(input int unsigned exp_w);
    return (32'd1 << (exp_w - 1)) - 32'd1;
  endfunction

  function automatic int unsigned exp_max_of(input int unsigned exp_w);
    return (32'd1 << exp_w) - 32'd1;
  endfunction

  // Sign 0, exponent all ones, fraction MSB set.
  function automatic logic [MAX_W-1:0] qnan_of(input int unsigned exp_w,
                                              input int unsigned man_w);
    logic [MAX_W-1:0] r;
    r = ((64'd1 << exp_w) - 64'd1) << man_w;
    r = r | (64'd1 << (man_w - 1));
    return r;
  endfunction

  function automatic logic get_sign(input logic [MAX_W-1:0] x, input int unsigned exp_w,
                                    input int unsigned man_w);
    return 1'(x >> (exp_w + man_w));
  endfunction

  function automatic logic [MAX_W-1:0] get_exp(input logic [MAX_W-1:0] x,
                                               input int unsigned exp_w,
                                               input int unsigned man_w);
    return (x >> man_w) & ((64'd1 << exp_w) - 64'd1);
  endfunction

  function automatic logic [MAX_W-1:0] get_frac(input logic [MAX_W-1:0] x,
                                                input int unsigned man_w);
    return x & ((64'd1 << man_w) - 64'd1);
  endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational operand classifier with flush-to-zero of subnormals.
// Ports:
//   op  - floating-point operand (1+EXP_W+MAN_W bits)
//   cls - class flags {zero, inf, nan, normal}, exactly one set
module fp_classify
  import fp_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23,
  localparam int unsigned DATA_WIDTH = 1 + EXP_W + MAN_W
) (
  input  logic [DATA_WIDTH-1:0] op,
  output fp_class_t             cls
);

  logic [EXP_W-1:0] exp_f;
  logic [MAN_W-1:0] frac_f;
  logic             exp_zero, exp_ones, frac_zero;

  assign exp_f     = EXP_W'(get_exp(MAX_W'(op), EXP_W, MAN_W));
  assign frac_f    = MAN_W'(get_frac(MAX_W'(op), MAN_W));
  assign exp_zero  = (exp_f == '0);
  assign exp_ones  = &exp_f;
  assign frac_zero = (frac_f == '0);

  // A zero exponent covers both true zero and subnormals (flushed).
  assign cls.zero   = exp_zero;
  assign cls.inf    = exp_ones & frac_zero;
  assign cls.nan    = exp_ones & ~frac_zero;
  assign cls.normal = ~exp_zero & ~exp_ones;

endmodule

// File: rtl/fp_div_seq.sv
// Sequential floating-point divider, m = a / b, restoring radix-2 with RNE.
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   in_valid/in_ready    - operand handshake for a (dividend), b (divisor)
//   out_valid/out_ready  - result handshake for m (quotient)
//   overflow, underflow, div_by_zero, invalid - result flags, valid with out_valid
module fp_div_seq
  import fp_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23,
  localparam int unsigned DATA_WIDTH = 1 + EXP_W + MAN_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] m,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  div_by_zero,
  output logic                  invalid
);

  localparam int unsigned QW    = MAN_W + 3;  // integer + MAN_W+1 fraction + guard
  localparam int unsigned RW    = MAN_W + 2;  // remainder, always < 2 * divisor
  localparam int unsigned SW    = EXP_W + 2;  // signed exponent working width
  localparam int unsigned CNT_W = $clog2(QW);

  localparam logic [DATA_WIDTH-1:0] QNAN   = DATA_WIDTH'(qnan_of(EXP_W, MAN_W));
  localparam logic signed [SW-1:0]  BIAS_S = SW'(bias_of(EXP_W));
  localparam logic signed [SW-1:0]  EMAX_S = SW'(exp_max_of(EXP_W));
  localparam logic signed [SW-1:0]  ONE_S  = SW'(1);
  localparam logic signed [SW-1:0]  ZERO_S = '0;
  localparam logic [CNT_W-1:0]      LAST   = CNT_W'(QW - 1);

  fp_class_t        cls_a, cls_b;
  logic             sign_ab;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (.op(a), .cls(cls_a));
  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (.op(b), .cls(cls_b));

  assign sign_ab = get_sign(MAX_W'(a), EXP_W, MAN_W) ^ get_sign(MAX_W'(b), EXP_W, MAN_W);
  assign ea      = EXP_W'(get_exp(MAX_W'(a), EXP_W, MAN_W));
  assign eb      = EXP_W'(get_exp(MAX_W'(b), EXP_W, MAN_W));
  assign fa      = MAN_W'(get_frac(MAX_W'(a), MAN_W));
  assign fb      = MAN_W'(get_frac(MAX_W'(b), MAN_W));

  // Special-case decode, evaluated on live operands at acceptance.
  logic                  is_special, spec_inv, spec_dbz;
  logic [DATA_WIDTH-1:0] spec_m;

  always_comb begin
    spec_inv   = (cls_a.zero & cls_b.zero) | (cls_a.inf & cls_b.inf);
    spec_dbz   = 1'b0;
    is_special = ~(cls_a.normal & cls_b.normal);
    if (cls_a.nan | cls_b.nan | spec_inv) begin
      spec_m = QNAN;
    end else if (cls_a.inf) begin
      spec_m = {sign_ab, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (cls_b.inf | cls_a.zero) begin
      spec_m = {sign_ab, {(EXP_W + MAN_W){1'b0}}};
    end else begin
      spec_m   = {sign_ab, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      spec_dbz = 1'b1;
    end
  end

  fp_state_e             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [RW-1:0]         rem_q, rem_d;
  logic [MAN_W:0]        mb_q, mb_d;
  logic [QW-1:0]         quo_q, quo_d;
  logic                  sign_q, sign_d;
  logic signed [SW-1:0]  exp_q, exp_d;
  logic [DATA_WIDTH-1:0] m_q, m_d;
  logic                  ovf_q, ovf_d, unf_q, unf_d, dbz_q, dbz_d, inv_q, inv_d;

  // Restoring step: subtract divisor when it fits, then shift remainder up.
  logic          rem_ge;
  logic [RW-1:0] rem_sub;

  assign rem_ge  = (rem_q >= {1'b0, mb_q});
  assign rem_sub = rem_ge ? (rem_q - {1'b0, mb_q}) : rem_q;

  // Normalise and round.
  logic [QW-1:0]        qn;
  logic signed [SW-1:0] exp_n, exp_r;
  logic [MAN_W:0]       mant;
  logic [MAN_W+1:0]     mant_r;
  logic                 guard, extra, sticky, rnd;
  logic [MAN_W-1:0]     frac_r;
  logic                 unused_hidden;

  assign qn      = quo_q[QW-1] ? quo_q : {quo_q[QW-2:0], 1'b0};
  assign exp_n   = quo_q[QW-1] ? exp_q : exp_q - ONE_S;
  assign mant    = qn[QW-1:2];
  assign guard   = qn[1];
  assign extra   = qn[0];
  assign sticky  = |rem_q;
  assign rnd     = guard & (extra | sticky | mant[0]);
  assign mant_r  = {1'b0, mant} + {{(MAN_W + 1){1'b0}}, rnd};
  // A rounding carry gives exactly 2.0, i.e. fraction zero at exponent + 1.
  assign exp_r   = mant_r[MAN_W+1] ? exp_n + ONE_S : exp_n;
  assign frac_r  = mant_r[MAN_W+1] ? '0 : mant_r[MAN_W-1:0];
  assign unused_hidden = mant_r[MAN_W];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    mb_d    = mb_q;
    quo_d   = quo_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    m_d     = m_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    dbz_d   = dbz_q;
    inv_d   = inv_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          if (is_special) begin
            m_d     = spec_m;
            inv_d   = spec_inv;
            dbz_d   = spec_dbz;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
            state_d = StDone;
          end else begin
            sign_d  = sign_ab;
            exp_d   = $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS_S;
            rem_d   = {1'b0, 1'b1, fa};
            mb_d    = {1'b1, fb};
            quo_d   = '0;
            cnt_d   = '0;
            state_d = StDivide;
          end
        end
      end
      StDivide: begin
        quo_d = {quo_q[QW-2:0], rem_ge};
        rem_d = {rem_sub[RW-2:0], 1'b0};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          state_d = StNorm;
        end
      end
      StNorm: begin
        ovf_d = 1'b0;
        unf_d = 1'b0;
        dbz_d = 1'b0;
        inv_d = 1'b0;
        if (exp_r >= EMAX_S) begin
          m_d   = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          ovf_d = 1'b1;
        end else if (exp_r <= ZERO_S) begin
          m_d   = {sign_q, {(EXP_W + MAN_W){1'b0}}};
          unf_d = 1'b1;
        end else begin
          m_d = {sign_q, exp_r[EXP_W-1:0], frac_r};
        end
        state_d = StDone;
      end
      StDone: begin
        if (out_ready) begin
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          dbz_d   = 1'b0;
          inv_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rem_q   <= '0;
      mb_q    <= '0;
      quo_q   <= '0;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      m_q     <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      dbz_q   <= 1'b0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      mb_q    <= mb_d;
      quo_q   <= quo_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      m_q     <= m_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      dbz_q   <= dbz_d;
      inv_q   <= inv_d;
    end
  end

  assign in_ready    = (state_q == StIdle) & ~rst;
  assign out_valid   = (state_q == StDone);
  assign m           = m_q;
  assign overflow    = ovf_q;
  assign underflow   = unf_q;
  assign div_by_zero = dbz_q;
  assign invalid     = inv_q;

endmodule

// File: tb/tb_fp_div_seq.sv
// Directed self-checking bench for fp_div_seq at default widths.
module tb_fp_div_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] m;
  logic        overflow, underflow, div_by_zero, invalid;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fp_div_seq #(.EXP_W(8), .MAN_W(23)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .m          (m),
    .overflow   (overflow),
    .underflow  (underflow),
    .div_by_zero(div_by_zero),
    .invalid    (invalid)
  );

  // Flags packed as {overflow, underflow, div_by_zero, invalid}.
  localparam int NV = 11;
  logic [31:0] va [NV] = '{32'h38140000, 32'h40C00000, 32'h3F800000, 32'h7F000000,
                           32'h00800000, 32'h00000000, 32'h3F800000, 32'h7FC00001,
                           32'hC0C00000, 32'h7F800000, 32'h40000000};
  logic [31:0] vb [NV] = '{32'h12800000, 32'h3FC00000, 32'h40400000, 32'h00800000,
                           32'h7F000000, 32'h80000000, 32'h80000000, 32'h3F800000,
                           32'h3FC00000, 32'h40000000, 32'h7F800000};
  logic [31:0] vm [NV] = '{32'h65140000, 32'h40800000, 32'h3EAAAAAB, 32'h7F800000,
                           32'h00000000, 32'h7FC00000, 32'hFF800000, 32'h7FC00000,
                           32'hC0800000, 32'h7F800000, 32'h00000000};
  logic [3:0]  vf [NV] = '{4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0100, 4'b0001,
                           4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
  int          vl [NV] = '{28, 28, 28, 28, 28, 1, 1, 1, 28, 1, 1};

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] flags();
    return {overflow, underflow, div_by_zero, invalid};
  endfunction

  // Issue vector i, hold out_ready low for 'hold' cycles after out_valid, then consume.
  task automatic run_vec(input int i, input int hold);
    int          lat;
    logic [31:0] m0;
    logic [3:0]  f0;
    @(negedge clk);
    check_eq($sformatf("in_ready_idle[%0d]", i), 64'(in_ready), 64'd1);
    a = va[i];
    b = vb[i];
    in_valid = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    a = '0;
    b = '0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check_eq($sformatf("latency[%0d]", i), 64'(lat), 64'(vl[i]));
    check_eq($sformatf("m[%0d]", i), 64'(m), 64'(vm[i]));
    check_eq($sformatf("flags[%0d]", i), 64'(flags()), 64'(vf[i]));
    check_eq($sformatf("busy_ready[%0d]", i), 64'(in_ready), 64'd0);
    m0 = m;
    f0 = flags();
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check_eq($sformatf("hold_m[%0d]", k), 64'(m), 64'(m0));
      check_eq($sformatf("hold_ctl[%0d]", k), 64'({out_valid, in_ready, flags()}),
               64'({1'b1, 1'b0, f0}));
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check_eq($sformatf("consumed[%0d]", i), 64'({out_valid, in_ready, flags()}),
             64'({1'b0, 1'b1, 4'b0000}));
  endtask

  initial begin
    int stale;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("ready_in_reset", 64'(in_ready), 64'd0);
    rst = 1'b0;
    #1;
    check_eq("reset_state", 64'({in_ready, out_valid, m, flags()}),
             64'({1'b1, 1'b0, 32'h0, 4'b0000}));

    for (int i = 0; i < NV; i++) run_vec(i, 0);
    run_vec(0, 10);

    // Reset during DIVIDE iteration 5.
    @(negedge clk);
    a = va[2];
    b = vb[2];
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("mid_reset_ctl", 64'({out_valid, in_ready}), 64'({1'b0, 1'b0}));
    rst = 1'b0;
    #1;
    check_eq("after_reset", 64'({in_ready, out_valid, m, flags()}),
             64'({1'b1, 1'b0, 32'h0, 4'b0000}));
    stale = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check_eq("no_stale_result", 64'(stale), 64'd0);
    run_vec(1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fp_div_seq.md
# fp_div_seq

Parametrised, multi-cycle IEEE-754-style floating-point divider producing `m = a / b`. It is the sequential successor of the combinational single-precision divider: generic exponent and mantissa widths, a restoring radix-2 mantissa datapath, round-to-nearest-even, and full special-value handling. Operands enter and results leave on valid/ready handshakes, so the block sits directly in a streaming FP pipeline.

## Interface
- `EXP_W`, default 8: exponent field width.
- `MAN_W`, default 23: stored fraction width, with the hidden bit excluded.
- `DATA_WIDTH` is derived as 1+EXP_W+MAN_W and is not overridable.

- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: operands valid.
- `in_ready` out 1: block can accept operands.
- `a` in DATA_WIDTH: dividend.
- `b` in DATA_WIDTH: divisor.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts result.
- `m` out DATA_WIDTH: quotient.
- `overflow` out 1: finite result exceeded the maximum exponent and was replaced by signed infinity.
- `underflow` out 1: result below the minimum normal and was flushed to signed zero.
- `div_by_zero` out 1: finite nonzero operand divided by zero.
- `invalid` out 1: 0/0 or inf/inf.

## Operation
- **Subnormal inputs:** treated as signed zero (flush-to-zero).
- **Subnormal results:** never produced.
- **Result sign:** `a[MSB] ^ b[MSB]` for every non-NaN result.
- **Special cases, decided at acceptance:**
  - Any NaN operand, 0/0 or inf/inf gives canonical qNaN: sign 0, exponent all ones, fraction MSB 1, rest 0. `invalid` is set only for 0/0 and inf/inf.
  - inf/finite gives signed inf with no flag.
  - finite/inf gives signed zero with no flag.
  - 0/finite-nonzero gives signed zero.
  - Finite-nonzero/0 gives signed inf with `div_by_zero` set.
- **Normal path:**
  - The exponent is computed as ea − eb + BIAS in EXP_W+2-bit signed arithmetic.
  - The divider produces MAN_W+3 quotient bits: one integer bit, MAN_W+1 fraction bits, and one guard bit. Sticky is set when the final remainder is nonzero.
  - If the integer bit is 0, the quotient shifts left one place and the exponent decrements.
  - Rounding is RNE using the guard bit and (extra bit | sticky). A mantissa carry out of rounding renormalises and increments the exponent.
- **Range check, after rounding:**
  - Exponent ≥ 2^EXP_W−1 gives signed inf with `overflow` set.
  - Exponent ≤ 0 gives signed zero with `underflow` set.
- **States:**
  - IDLE: `in_ready`=1. On handshake, capture operands. Special case → DONE. Otherwise → DIVIDE.
  - DIVIDE: one quotient bit per cycle. The iteration counter runs from 0 to MAN_W+2, then → NORM.
  - NORM: normalise, round, range check, register `m` and flags, → DONE.
  - DONE: `out_valid`=1, with `m` and flags held stable. On `out_valid && out_ready` → IDLE.
- Flags are mutually exclusive and valid only while `out_valid`=1. They are 0 in every other state.

## Timing
- **Reset:** the edge with `rst`=1 forces IDLE. After that edge, `out_valid`, `m` and all four flags are 0 and `in_ready` is 1. While `rst`=1, `in_ready` is driven 0.
- **Reset mid-operation:** any in-flight operation is discarded and no result is emitted.
- **Cycle numbering:** cycle 0 is the acceptance edge.
- **Normal-path latency:** `out_valid` rises after MAN_W+5 edges, which is 28 for the defaults.
- **Special-case latency:** `out_valid` rises after 1 edge.
- **Ready rule:** `in_ready` is 0 in DIVIDE, NORM and DONE. No new operand is accepted on the cycle the result is consumed.
- **Throughput:** the minimum issue interval is MAN_W+6 cycles on the normal path and 2 cycles on the special-case path.
- **Backpressure:** holding `out_ready`=0 keeps the block in DONE indefinitely, with outputs unchanged.

## Structure
- **Package `fp_pkg`:**
  - BIAS, EXP_MAX and the canonical-qNaN constant, each expressed as a function of EXP_W and MAN_W.
  - Field-extract helpers for sign, exponent and fraction.
  - The state enum: IDLE, DIVIDE, NORM, DONE.
  - The class struct with fields zero, inf, nan and normal.
- **Sub-module `fp_classify`:**
  - Purely combinational. It classifies one operand, applying flush-to-zero for subnormals.
  - `fp_div_seq` instantiates it twice, once for `a` and once for `b`.

## Test plan
All vectors use the default widths.
- **Exact quotients:**
  - 0x38140000 / 0x12800000 → 0x65140000 with no flags, `out_valid` exactly 28 cycles after acceptance.
  - 0x40C00000 / 0x3FC00000 → 0x40800000.
- **Rounding:** 0x3F800000 / 0x40400000 → 0x3EAAAAAB, exercising RNE round-up via sticky.
- **Range limits:**
  - 0x7F000000 / 0x00800000 → 0x7F800000 with `overflow`=1.
  - 0x00800000 / 0x7F000000 → 0x00000000 with `underflow`=1.
- **Special values:**
  - 0x00000000 / 0x80000000 → 0x7FC00000 with `invalid`=1, 1-cycle latency.
  - 0x3F800000 / 0x80000000 → 0xFF800000 with `div_by_zero`=1.
  - 0x7FC00001 / 0x3F800000 → 0x7FC00000 with no flags.
- **Backpressure and reset:**
  - Hold `out_ready`=0 for 10 cycles after `out_valid`: `m` and flags stay stable and `in_ready` stays 0.
  - In a separate run, assert `rst` at DIVIDE iteration 5: the next cycle shows IDLE with `out_valid`=0, and no stale result appears later.
